// File: rtl/lcd_pattern_gen_if.sv
// LCD panel bus: pattern select in, sync/enable/colour out.
// Master is the pattern generator; slave is the panel side.
interface lcd_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic [1:0]         i_mode;
  logic               o_grest;
  logic               o_hd;
  logic               o_vd;
  logic               o_den;
  logic               o_frame_start;
  logic [COLOR_W-1:0] o_r;
  logic [COLOR_W-1:0] o_g;
  logic [COLOR_W-1:0] o_b;

  modport master (
    input  i_mode,
    output o_grest, o_hd, o_vd, o_den, o_frame_start, o_r, o_g, o_b
  );

  modport slave (
    output i_mode,
    input  o_grest, o_hd, o_vd, o_den, o_frame_start, o_r, o_g, o_b
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// LCD timing + test-pattern generator, one clock per pixel.
// Patterns: 0 vertical bars, 1 horizontal bars, 2 checkerboard,
// 3 scrolling vertical bars. MODE is latched only at frame start.
// All outputs are registered and describe the previous cycle's counters.
// Optional macro LCD_PATTERN_BORDER_EN forces a white 1-pixel frame border.
// Assumes non-zero horizontal and vertical blanking, and that SCROLL_STEP
// is smaller than the number of clocks in the vertical back porch, since
// the offset is advanced one pixel per clock after frame start.
module lcd_pattern_gen #(
  parameter int BACK_PORCH_X  = 216,
  parameter int BACK_PORCH_Y  = 35,
  parameter int FRONT_PORCH_X = 40,
  parameter int FRONT_PORCH_Y = 10,
  parameter int SCREEN_SIZE_X = 800,
  parameter int SCREEN_SIZE_Y = 480,
  parameter int NUM_BARS      = 8,
  parameter int COLOR_W       = 8,
  parameter int CHECK_LOG2    = 5,
  parameter int SCROLL_STEP   = 4
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  lcd_pattern_gen_if.master     bus
);
  localparam int H_TOTAL = BACK_PORCH_X + SCREEN_SIZE_X + FRONT_PORCH_X;
  localparam int V_TOTAL = BACK_PORCH_Y + SCREEN_SIZE_Y + FRONT_PORCH_Y;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int XW = $clog2(SCREEN_SIZE_X + 1);
  localparam int YW = $clog2(SCREEN_SIZE_Y + 1);
  localparam int SW = $clog2(SCROLL_STEP + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HA_LO   = HW'(BACK_PORCH_X);
  localparam logic [HW-1:0] HA_HI   = HW'(BACK_PORCH_X + SCREEN_SIZE_X);
  localparam logic [VW-1:0] VA_LO   = VW'(BACK_PORCH_Y);
  localparam logic [VW-1:0] VA_HI   = VW'(BACK_PORCH_Y + SCREEN_SIZE_Y);
  localparam logic [HW-1:0] HX_MASK = HW'(1) << CHECK_LOG2;
  localparam logic [VW-1:0] VY_MASK = VW'(1) << CHECK_LOG2;
  localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_SIZE_X - 1);
  localparam logic [XW-1:0] BW_LAST = XW'(SCREEN_SIZE_X / NUM_BARS - 1);
  localparam logic [YW-1:0] BH_LAST = YW'(SCREEN_SIZE_Y / NUM_BARS - 1);
  localparam logic [5:0]    BAR_LAST = 6'(NUM_BARS - 1);
  localparam logic [SW-1:0] STEP    = SW'(SCROLL_STEP);

  // Position along the (possibly wrapped) line, pixel-in-bar and bar index.
  typedef struct packed {
    logic [XW-1:0] pos;
    logic [XW-1:0] px;
    logic [5:0]    bar;
  } col_t;

  typedef struct packed {
    logic [YW-1:0] px;
    logic [5:0]    bar;
  } row_t;

  // One pixel step; the last bar absorbs the remainder pixels.
  function automatic col_t f_col_step(input col_t c);
    col_t n;
    n = c;
    if (c.pos == X_LAST) begin
      n = '0;
    end else begin
      n.pos = c.pos + XW'(1);
      if (c.px == BW_LAST && c.bar != BAR_LAST) begin
        n.px  = '0;
        n.bar = c.bar + 6'd1;
      end else begin
        n.px = c.px + XW'(1);
      end
    end
    return n;
  endfunction

  function automatic row_t f_row_step(input row_t r);
    row_t n;
    n = r;
    if (r.px == BH_LAST && r.bar != BAR_LAST) begin
      n.px  = '0;
      n.bar = r.bar + 6'd1;
    end else begin
      n.px = r.px + YW'(1);
    end
    return n;
  endfunction

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic [1:0]    r_mode;
  col_t          r_off;
  logic [SW-1:0] r_pend;
  col_t          r_col;
  row_t          r_row;

  logic               r_grest, r_hd, r_vd, r_den, r_fs;
  logic [COLOR_W-1:0] r_r, r_g, r_b;

  logic       w_hact, w_vact, w_act, w_fs, w_hwrap;
  logic       w_cx, w_cy;
  logic [2:0] w_idx;
  logic [2:0] w_rgb;

  assign w_hact  = (r_hcount >= HA_LO) && (r_hcount < HA_HI);
  assign w_vact  = (r_vcount >= VA_LO) && (r_vcount < VA_HI);
  assign w_act   = w_hact && w_vact;
  assign w_fs    = (r_hcount == '0) && (r_vcount == '0);
  assign w_hwrap = (r_hcount == H_LAST);
  assign w_cx    = |((r_hcount - HA_LO) & HX_MASK);
  assign w_cy    = |((r_vcount - VA_LO) & VY_MASK);

  // Timing counters, mode latch, scroll offset and bar walkers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_mode   <= '0;
      r_off    <= '0;
      r_pend   <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      r_hcount <= w_hwrap ? '0 : r_hcount + HW'(1);
      if (w_hwrap)
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + VW'(1);

      // Offset moves one pixel per clock during vertical blanking so the
      // bar preload never needs a divider.
      if (w_fs) begin
        r_mode <= bus.i_mode;
        if (r_mode == 2'd3) r_pend <= STEP;
      end else if (r_pend != '0) begin
        r_off  <= f_col_step(r_off);
        r_pend <= r_pend - SW'(1);
      end

      // Column walker: preloaded in horizontal blanking, steps per pixel.
      if (w_hact)
        r_col <= f_col_step(r_col);
      else
        r_col <= (r_mode == 2'd3) ? r_off : '0;

      // Row walker: steps on each line wrap inside the active rows.
      if (w_hwrap)
        r_row <= w_vact ? f_row_step(r_row) : '0;
    end
  end

  // Palette index for the current pixel.
  always_comb begin
    w_idx = 3'd0;
    case (r_mode)
      2'd1:    w_idx = r_row.bar[2:0];
      2'd2:    w_idx = (w_cx ^ w_cy) ? 3'd7 : 3'd0;
      default: w_idx = r_col.bar[2:0];
    endcase
`ifdef LCD_PATTERN_BORDER_EN
    if (r_hcount == HA_LO || r_hcount == HA_HI - HW'(1) ||
        r_vcount == VA_LO || r_vcount == VA_HI - VW'(1))
      w_idx = 3'd0;
`endif
    // white, yellow, cyan, green, magenta, red, blue, black
    w_rgb = {~w_idx[1], ~w_idx[2], ~w_idx[0]};
  end

  // Registered panel outputs, one clock behind the counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grest <= 1'b0;
      r_hd    <= 1'b1;
      r_vd    <= 1'b1;
      r_den   <= 1'b0;
      r_fs    <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_grest <= 1'b1;
      r_hd    <= (r_hcount != '0);
      r_vd    <= (r_vcount != '0);
      r_den   <= w_act;
      r_fs    <= w_fs;
      r_r     <= {COLOR_W{w_act & w_rgb[2]}};
      r_g     <= {COLOR_W{w_act & w_rgb[1]}};
      r_b     <= {COLOR_W{w_act & w_rgb[0]}};
    end
  end

  assign bus.o_grest       = r_grest;
  assign bus.o_hd          = r_hd;
  assign bus.o_vd          = r_vd;
  assign bus.o_den         = r_den;
  assign bus.o_frame_start = r_fs;
  assign bus.o_r           = r_r;
  assign bus.o_g           = r_g;
  assign bus.o_b           = r_b;
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a small 18x8 screen
// (H_TOTAL 24, V_TOTAL 11, 8 bars of width 2 with a 2-pixel remainder).
module tb_lcd_pattern_gen;
  localparam int BPX = 4, BPY = 2, FPX = 2, FPY = 1;
  localparam int SX = 18, SY = 8, NB = 8, CW = 8, CL = 1, SS = 4;
  localparam int HT = BPX + SX + FPX;
  localparam int VT = BPY + SY + FPY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_pattern_gen_if #(.COLOR_W(CW)) bus();

  lcd_pattern_gen #(
    .BACK_PORCH_X(BPX), .BACK_PORCH_Y(BPY), .FRONT_PORCH_X(FPX),
    .FRONT_PORCH_Y(FPY), .SCREEN_SIZE_X(SX), .SCREEN_SIZE_Y(SY),
    .NUM_BARS(NB), .COLOR_W(CW), .CHECK_LOG2(CL), .SCROLL_STEP(SS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] pix [0:SY-1][0:SX-1];
  int den_cnt [0:VT-1];
  int den_lines;

  // Sync period monitor.
  int cyc = 0, last_hd = -1, hd_gap = 0, last_vdf = -1, vd_gap = 0;
  logic prev_vd = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (bus.o_hd === 1'b0) begin
      if (last_hd >= 0) hd_gap = cyc - last_hd;
      last_hd = cyc;
    end
    if (bus.o_vd === 1'b0 && prev_vd === 1'b1) begin
      if (last_vdf >= 0) vd_gap = cyc - last_vdf;
      last_vdf = cyc;
    end
    prev_vd = bus.o_vd;
  end

  function automatic logic [2:0] pal(input int idx);
    case (idx)
      0: return 3'b111;  // white
      1: return 3'b110;  // yellow
      2: return 3'b011;  // cyan
      3: return 3'b010;  // green
      4: return 3'b101;  // magenta
      5: return 3'b100;  // red
      6: return 3'b001;  // blue
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] exp_rgb(input int mode, input int off,
                                         input int x, input int y);
    int idx;
    int p;
    case (mode)
      0: idx = x / (SX / NB);
      1: idx = y / (SY / NB);
      2: idx = ((((x >> CL) & 1) ^ ((y >> CL) & 1)) != 0) ? 7 : 0;
      default: begin
        p   = (x + off) % SX;
        idx = p / (SX / NB);
      end
    endcase
    if (mode != 2 && idx > NB - 1) idx = NB - 1;
`ifdef LCD_PATTERN_BORDER_EN
    if (x == 0 || x == SX - 1 || y == 0 || y == SY - 1) idx = 0;
`endif
    return pal(idx % 8);
  endfunction

  // Walks rows 0..stop_row-1 starting at a frame-start sample, checking every
  // output against the model; optionally changes MODE at row chg_row.
  task automatic check_frame(input int mode, input int off, input int chg_row,
                             input int chg_mode, input int stop_row);
    logic [27:0] obs, expv;
    logic [2:0]  e;
    bit act;
    den_lines = 0;
    for (int v = 0; v < VT; v++) den_cnt[v] = 0;
    for (int v = 0; v < stop_row; v++) begin
      for (int h = 0; h < HT; h++) begin
        act  = (h >= BPX) && (h < BPX + SX) && (v >= BPY) && (v < BPY + SY);
        e    = act ? exp_rgb(mode, off, h - BPX, v - BPY) : 3'b000;
        expv = {(h == 0 && v == 0), (h != 0), (v != 0), act,
                {8{e[2]}}, {8{e[1]}}, {8{e[0]}}};
        obs  = {bus.o_frame_start, bus.o_hd, bus.o_vd, bus.o_den,
                bus.o_r, bus.o_g, bus.o_b};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL frame_px mode=%0d off=%0d h=%0d v=%0d: got %h expected %h",
                   mode, off, h, v, obs, expv);
        end
        if (act) pix[v - BPY][h - BPX] = {bus.o_r, bus.o_g, bus.o_b};
        if (bus.o_den === 1'b1) begin
          den_cnt[v]++;
          if (den_cnt[v] == 1) den_lines++;
        end
        if (chg_row >= 0 && v == chg_row && h == 0) bus.i_mode = 2'(chg_mode);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_mode = 2'd0;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.o_grest, bus.o_hd, bus.o_vd, bus.o_den, bus.o_frame_start} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_ctrl: got grest/hd/vd/den/fs=%b expected 01100",
               {bus.o_grest, bus.o_hd, bus.o_vd, bus.o_den, bus.o_frame_start});
    end
    checks++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %h expected 000000", {bus.o_r, bus.o_g, bus.o_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_grest, bus.o_frame_start, bus.o_hd, bus.o_vd} !== 4'b1100) begin
      errors++;
      $display("FAIL release: got grest/fs/hd/vd=%b expected 1100",
               {bus.o_grest, bus.o_frame_start, bus.o_hd, bus.o_vd});
    end
  endtask

  task automatic test_vbars();
    int xs [4];
    logic [23:0] es [4];
    xs = '{1, 2, 3, 16};
    es = '{24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h000000};
    check_frame(0, 0, 5, 1, VT);   // MODE goes to 1 mid-frame
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix[3][xs[i]] !== es[i]) begin
        errors++;
        $display("FAIL vbar_x%0d: got %h expected %h", xs[i], pix[3][xs[i]], es[i]);
      end
    end
    checks++;
    if (den_cnt[BPY + 3] != SX) begin
      errors++;
      $display("FAIL den_per_line: got %0d expected %0d", den_cnt[BPY + 3], SX);
    end
    checks++;
    if (den_lines != SY) begin
      errors++;
      $display("FAIL lines_per_frame: got %0d expected %0d", den_lines, SY);
    end
    checks++;
    if (hd_gap != HT) begin
      errors++;
      $display("FAIL hd_period: got %0d expected %0d", hd_gap, HT);
    end
  endtask

  task automatic test_hbars();
    int ys [3];
    int xs [3];
    logic [23:0] es [3];
    ys = '{1, 2, 6};
    xs = '{5, 16, 5};
    es = '{24'hFFFF00, 24'h00FFFF, 24'h0000FF};
    check_frame(1, 0, 5, 2, VT);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix[ys[i]][xs[i]] !== es[i]) begin
        errors++;
        $display("FAIL hbar_y%0d_x%0d: got %h expected %h",
                 ys[i], xs[i], pix[ys[i]][xs[i]], es[i]);
      end
    end
    checks++;
    if (vd_gap != HT * VT) begin
      errors++;
      $display("FAIL vd_period: got %0d expected %0d", vd_gap, HT * VT);
    end
  endtask

  task automatic test_checker();
    int ys [3];
    int xs [3];
    logic [23:0] es [3];
    ys = '{1, 1, 2};
    xs = '{1, 2, 2};
    es = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    check_frame(2, 0, 5, 3, VT);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix[ys[i]][xs[i]] !== es[i]) begin
        errors++;
        $display("FAIL checker_x%0d_y%0d: got %h expected %h",
                 xs[i], ys[i], pix[ys[i]][xs[i]], es[i]);
      end
    end
  endtask

  task automatic test_scroll();
    int offs [10];
    offs = '{0, 4, 8, 12, 16, 2, 6, 10, 14, 0};
    for (int f = 0; f < 10; f++) begin
      check_frame(3, offs[f], (f == 9) ? 5 : -1, 0, VT);
      if (f == 0 || f == 9) begin
        checks++;
        if (pix[3][1] !== 24'hFFFFFF || pix[3][16] !== 24'h000000) begin
          errors++;
          $display("FAIL scroll_off0_f%0d: got %h/%h expected FFFFFF/000000",
                   f, pix[3][1], pix[3][16]);
        end
      end
      if (f == 1) begin
        checks++;
        if (pix[3][1] !== 24'h00FFFF || pix[3][16] !== 24'hFFFF00) begin
          errors++;
          $display("FAIL scroll_off4: got %h/%h expected 00FFFF/FFFF00",
                   pix[3][1], pix[3][16]);
        end
      end
    end
  endtask

  task automatic test_mode_switch_and_reset();
    check_frame(0, 0, 5, 2, VT);    // 0 -> 2 mid-frame; bars persist
    checks++;
    if (pix[6][2] !== 24'hFFFF00) begin
      errors++;
      $display("FAIL latch_rest_of_frame: got %h expected FFFF00", pix[6][2]);
    end
    check_frame(2, 0, -1, 0, 6);    // checkerboard, interrupted at row 6
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_grest, bus.o_hd, bus.o_vd, bus.o_den, bus.o_frame_start} !== 5'b01100 ||
        {bus.o_r, bus.o_g, bus.o_b} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: got ctrl=%b rgb=%h expected 01100/000000",
               {bus.o_grest, bus.o_hd, bus.o_vd, bus.o_den, bus.o_frame_start},
               {bus.o_r, bus.o_g, bus.o_b});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_frame_start, bus.o_vd, bus.o_hd, bus.o_grest} !== 4'b1001) begin
      errors++;
      $display("FAIL restart: got fs/vd/hd/grest=%b expected 1001",
               {bus.o_frame_start, bus.o_vd, bus.o_hd, bus.o_grest});
    end
    check_frame(2, 0, -1, 0, VT);   // MODE=2 relatched at the fresh frame
  endtask

  initial begin
    test_reset();
    test_vbars();
    test_hbars();
    test_checker();
    test_scroll();
    test_mode_switch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
- Self-contained LCD timing and test-pattern generator, parametrised in resolution, porches, bar count and colour depth.
- Replaces the fixed 8-bar generator. Adds selectable patterns (vertical bars, horizontal bars, checkerboard, scrolling bars) with frame-synchronous mode switching.
- Drives the panel's HD/VD/DEN/GREST and RGB buses directly. One clock = one pixel.

Parameters:
- BACK_PORCH_X, 216, horizontal clocks before active pixels
- BACK_PORCH_Y, 35, lines before active lines
- FRONT_PORCH_X, 40, horizontal clocks after active pixels
- FRONT_PORCH_Y, 10, lines after active lines
- SCREEN_SIZE_X, 800, active pixels per line
- SCREEN_SIZE_Y, 480, active lines per frame
- NUM_BARS, 8, bars across (mode 0/3) or down (mode 1); range 1..64
- COLOR_W, 8, bits per colour channel
- CHECK_LOG2, 5, log2 of checkerboard cell size in pixels
- SCROLL_STEP, 4, pixels advanced per frame in scroll mode; must be < SCREEN_SIZE_X

Ports:
- CLK  in  1  pixel clock
- RST_n  in  1  asynchronous active-low reset
- MODE  in  2  pattern select: 0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 scrolling vertical bars
- GREST  out  1  panel global reset, active-low
- HD  out  1  horizontal sync, active-low
- VD  out  1  vertical sync, active-low
- DEN  out  1  data enable, high on active pixels
- R, G, B  out  COLOR_W each  pixel colour
- FRAME_START  out  1  one-cycle pulse at hcount=0, vcount=0

Behaviour:
- Reset is asynchronous active-low on RST_n. Single clock CLK; all state is in the CLK domain.
- H_TOTAL = BACK_PORCH_X + SCREEN_SIZE_X + FRONT_PORCH_X (1056 by default). V_TOTAL = BACK_PORCH_Y + SCREEN_SIZE_Y + FRONT_PORCH_Y (525 by default).
- hcount counts 0..H_TOTAL-1 and wraps to 0. vcount increments on each hcount wrap and wraps after V_TOTAL-1.
- Active region: BACK_PORCH_X <= hcount < BACK_PORCH_X+SCREEN_SIZE_X, and BACK_PORCH_Y <= vcount < BACK_PORCH_Y+SCREEN_SIZE_Y.
- x = hcount-BACK_PORCH_X and y = vcount-BACK_PORCH_Y within the active region.
- All outputs are registered. Latency is 1 clock from the counter state: the outputs in cycle n+1 describe the counters in cycle n. DEN, HD, VD and RGB are mutually aligned.
- HD is low for exactly 1 clock when hcount=0. VD is low for the whole line vcount=0 (H_TOTAL clocks).
- R=G=B=0 whenever DEN=0.
- GREST is 0 in reset. It goes to 1 on the first clock after RST_n rises and stays 1.
- Reset values:
  - hcount=vcount=0, scroll offset=0, active mode=0.
  - HD=VD=1, DEN=0, R=G=B=0, FRAME_START=0, GREST=0.
- Mode latch: MODE is sampled only at hcount=0, vcount=0 (frame start). A MODE change mid-frame takes effect on the next frame, never within one.
- Bar width BW = SCREEN_SIZE_X/NUM_BARS. Bar height BH = SCREEN_SIZE_Y/NUM_BARS.
  - Bar index is produced by a pixel-in-bar counter plus a bar counter, not a divider.
  - The index saturates at NUM_BARS-1, so remainder pixels join the last bar.
- Palette (index mod 8): 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black. Channels are all-ones or 0.
- Mode 0: index = x/BW.
- Mode 1: index = y/BH. The row-bar counter advances on the line wrap.
- Mode 2: white if bit CHECK_LOG2 of x XOR bit CHECK_LOG2 of y is 0, else black.
- Mode 3: index = ((x+offset) mod SCREEN_SIZE_X)/BW.
  - The offset advances by SCROLL_STEP at each frame start while mode 3 is latched. If the sum is >= SCREEN_SIZE_X, subtract SCREEN_SIZE_X.
  - The offset is held (not cleared) in other modes.
  - The per-line bar counter is preloaded from the offset at the line start.
- Reset asserted mid-frame: all state returns to reset values immediately. The first frame after release starts at hcount=0, vcount=0, with FRAME_START pulsing 1 clock after release.

Optional Feature:
- Macro: LCD_PATTERN_BORDER_EN.
- Defined: active pixels with x=0, x=SCREEN_SIZE_X-1, y=0 or y=SCREEN_SIZE_Y-1 are forced to white in every mode, on top of the pattern.
- Undefined: no border logic; the pattern covers the full active area.

Test Plan:
- Reset held 10 clocks, then released → GREST=0, HD=VD=1, DEN=0, RGB=0 during reset; GREST=1 and FRAME_START=1 one clock after release.
- MODE=0, default params, first active line → x=0 and x=99 white (FF,FF,FF); x=100 yellow (FF,FF,00); x=799 black. 800 DEN clocks per line; 480 lines per frame; HD period 1056, VD period 1056*525.
- MODE=1 → active line y=0 white, y=60 yellow, y=479 black; every pixel in a line has the same colour.
- MODE=2 → (x=0,y=0) white, (31,0) white, (32,0) black, (32,32) white.
- MODE=3, SCROLL_STEP=4 → frame 1 offset 0: x=96 white. Frame 2 offset 4: x=96 yellow. After 200 frames the offset wraps to 0.
- MODE changed 0→2 at vcount=100 → rest of the frame stays bars; the next frame is checkerboard. RST_n pulsed at vcount=300 → counters restart; the next VD low starts 1 clock after release.
